// File: rtl/chdr_pkg.sv
// Shared CHDR definitions: tuser descriptor bit positions, packet type and sequencer states.
package chdr_pkg;

  localparam int TYPE_HI  = 127;
  localparam int TYPE_LO  = 126;
  localparam int HAS_TIME = 125;
  localparam int EOB      = 124;
  localparam int SEQ_HI   = 123;
  localparam int SEQ_LO   = 112;
  localparam int LEN_HI   = 111;
  localparam int LEN_LO   = 96;
  localparam int SID_HI   = 95;
  localparam int SID_LO   = 64;
  localparam int TIME_HI  = 63;
  localparam int TIME_LO  = 0;

  localparam logic [1:0] PKT_TYPE_DATA = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/chdr_framer_seq_if.sv
// Sample-in / framer-out stream bundle for the CHDR framer sequencer.
interface chdr_framer_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] s_tdata;
  logic             s_teob;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic [127:0]     m_tuser;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;

  // master: the sequencer, which drives the framer-facing stream
  modport master (
    input  s_tdata, s_teob, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );

  // slave: the surroundings (sample source and framer)
  modport slave (
    output s_tdata, s_teob, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );
endinterface

// File: rtl/chdr_tuser_gen.sv
// Owns seqnum, the running sample time, the armed burst-start time and the
// registered tuser descriptor that stays stable for a whole packet.
module chdr_tuser_gen
  import chdr_pkg::*;
#(
  parameter int unsigned SAMPS_PER_WORD = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_beat,
  input  logic         i_tlast_beat,
  input  logic         i_eob,
  input  logic [31:0]  i_sid,
  input  logic [63:0]  i_cmd_time,
  input  logic         i_cmd_time_valid,
  output logic [127:0] o_tuser
);

  logic [11:0]  r_seqnum;
  logic [63:0]  r_time_acc;
  logic [63:0]  r_cmd_time;
  logic         r_time_armed;
  logic         r_burst_timed;
  logic [127:0] r_tuser;

  logic [11:0]  w_seq_next;
  logic [63:0]  w_time_next;
  logic         w_timed_next;
  logic [127:0] w_tuser_next;

  // Descriptor is built from the post-update counters so its time is that of
  // the first sample of the packet it describes.
  always_comb begin
    w_time_next = r_time_acc;
    if (i_start && r_time_armed)
      w_time_next = r_cmd_time;
    else if (i_beat)
      w_time_next = r_time_acc + 64'(SAMPS_PER_WORD);

    w_seq_next   = i_tlast_beat ? r_seqnum + 12'd1 : r_seqnum;
    w_timed_next = i_start ? r_time_armed : r_burst_timed;

    w_tuser_next                   = '0;
    w_tuser_next[TYPE_HI:TYPE_LO]  = PKT_TYPE_DATA;
    w_tuser_next[HAS_TIME]         = w_timed_next;
    w_tuser_next[SEQ_HI:SEQ_LO]    = w_seq_next;
    w_tuser_next[LEN_HI:LEN_LO]    = '0;
    w_tuser_next[SID_HI:SID_LO]    = i_sid;
    w_tuser_next[TIME_HI:TIME_LO]  = w_time_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seqnum      <= '0;
      r_time_acc    <= '0;
      r_cmd_time    <= '0;
      r_time_armed  <= 1'b0;
      r_burst_timed <= 1'b0;
      r_tuser       <= '0;
    end else begin
      r_seqnum      <= w_seq_next;
      r_time_acc    <= w_time_next;
      r_burst_timed <= w_timed_next;
      // A pulse coinciding with burst start re-arms for the following burst.
      if (i_cmd_time_valid) begin
        r_time_armed <= 1'b1;
        r_cmd_time   <= i_cmd_time;
      end else if (i_start) begin
        r_time_armed <= 1'b0;
      end
      if (i_start || i_tlast_beat)
        r_tuser <= w_tuser_next;
    end
  end

  always_comb begin
    o_tuser      = r_tuser;
    o_tuser[EOB] = r_tuser[EOB] | i_eob;
  end

endmodule

// File: rtl/chdr_framer_seq.sv
// Cuts a sample stream into cfg_spp-word packets for the CHDR framer and
// sequences bursts; zero-latency passthrough gated by the run state.
module chdr_framer_seq
  import chdr_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SAMPS_PER_WORD = WIDTH / 32
) (
  input  logic               samp_clk,
  input  logic               samp_rst_n,
  input  logic               cfg_enable,
  input  logic [15:0]        cfg_spp,
  input  logic [31:0]        cfg_sid,
  input  logic [63:0]        cmd_time,
  input  logic               cmd_time_valid,
  chdr_framer_seq_if.master  io,
  output logic               busy
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_word_cnt;
  logic [15:0] r_spp_l;
  logic [15:0] w_spp_cfg;
  logic        w_run;
  logic        w_beat;
  logic        w_tlast_beat;
  logic        w_start;

  assign w_run        = (r_state == ST_RUN);
  assign w_spp_cfg    = (cfg_spp == '0) ? 16'd1 : cfg_spp;

  assign io.m_tdata   = io.s_tdata;
  assign io.m_tvalid  = io.s_tvalid & w_run;
  assign io.s_tready  = io.m_tready & w_run;
  assign io.m_tlast   = w_run & ((r_word_cnt == (r_spp_l - 16'd1)) | io.s_teob);
  assign busy         = w_run;

  assign w_beat       = io.s_tvalid & io.s_tready;
  assign w_tlast_beat = w_beat & io.m_tlast;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_enable) begin
          w_state_next = ST_RUN;
          w_start      = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_tlast_beat && (io.s_teob || !cfg_enable))
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge samp_clk or negedge samp_rst_n) begin
    if (!samp_rst_n) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_spp_l    <= 16'd1;
    end else begin
      r_state <= w_state_next;
      if (w_tlast_beat)
        r_word_cnt <= '0;
      else if (w_beat)
        r_word_cnt <= r_word_cnt + 16'd1;
      // Config is only taken at packet boundaries so a change never splits a packet.
      if (w_start || w_tlast_beat)
        r_spp_l <= w_spp_cfg;
    end
  end

  chdr_tuser_gen #(
    .SAMPS_PER_WORD (SAMPS_PER_WORD)
  ) u_tuser_gen (
    .i_clk            (samp_clk),
    .i_rst_n          (samp_rst_n),
    .i_start          (w_start),
    .i_beat           (w_beat),
    .i_tlast_beat     (w_tlast_beat),
    .i_eob            (w_run & io.s_teob),
    .i_sid            (cfg_sid),
    .i_cmd_time       (cmd_time),
    .i_cmd_time_valid (cmd_time_valid),
    .o_tuser          (io.m_tuser)
  );

endmodule
